// File: rtl/agrupa_4_num_if.sv
// Purpose : bundle of the serial-word input handshake and the assembled-frame
//           output handshake of agrupa_4_num.
// Ports   : upstream  in_valid/in_ready/in_data/in_cresc_ou_desc/flush
//           downstream desordenado[3:0]/ena/cresc_ou_desc/out_ready/frame_cnt
// master = the environment driving words and consuming frames; slave = the block.
interface agrupa_4_num_if #(
  parameter int W = 9
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_cresc_ou_desc;
  logic         flush;
  logic [W-1:0] desordenado [3:0];
  logic         ena;
  logic         cresc_ou_desc;
  logic         out_ready;
  logic [7:0]   frame_cnt;

  modport master (
    output in_valid, in_data, in_cresc_ou_desc, flush, out_ready,
    input  in_ready, desordenado, ena, cresc_ou_desc, frame_cnt
  );

  modport slave (
    input  in_valid, in_data, in_cresc_ou_desc, flush, out_ready,
    output in_ready, desordenado, ena, cresc_ou_desc, frame_cnt
  );
endinterface

// File: rtl/agrupa_4_num.sv
// Purpose : groups 4 serial W-bit words into one frame for the sorter, with the
//           sort direction captured on word 0 of each frame.
// Latency : the frame (ena=1) is visible the cycle after its 4th word is taken.
// Backpressure: words 0..2 of the next frame are taken while a frame is held;
//           the 4th word stalls (in_ready=0) until the held frame is consumed.
// Ports   : clk, rst_n (async active-low), bus (agrupa_4_num_if.slave).
module agrupa_4_num #(
  parameter int W = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  agrupa_4_num_if.slave   bus
);

  // Fill count of the input buffer doubles as the state.
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;
  localparam logic [1:0] S_THREE = 2'd3;

  logic [1:0]   r_state;
  logic [W-1:0] r_buf [0:2];
  logic         r_dir;
  logic [W-1:0] r_desord [3:0];
  logic         r_ena;
  logic         r_cod;
  logic [7:0]   r_cnt;

  logic w_in_ready;
  logic w_xfer;
  logic w_handoff;
  logic w_complete;

  // Only the frame-completing word must wait for the held frame to drain;
  // earlier words go into the fill buffer, which is separate from the output.
  assign w_in_ready = !bus.flush &&
                      !((r_state == S_THREE) && r_ena && !bus.out_ready);
  assign w_xfer     = bus.in_valid && w_in_ready;
  assign w_handoff  = r_ena && bus.out_ready;
  assign w_complete = w_xfer && (r_state == S_THREE);

  // Fill state and buffered words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_EMPTY;
      r_buf[0] <= '0;
      r_buf[1] <= '0;
      r_buf[2] <= '0;
      r_dir    <= 1'b0;
    end else if (bus.flush) begin
      r_state <= S_EMPTY;
    end else if (w_xfer) begin
      case (r_state)
        S_EMPTY: begin
          r_buf[0] <= bus.in_data;
          r_dir    <= bus.in_cresc_ou_desc;
          r_state  <= S_ONE;
        end
        S_ONE: begin
          r_buf[1] <= bus.in_data;
          r_state  <= S_TWO;
        end
        S_TWO: begin
          r_buf[2] <= bus.in_data;
          r_state  <= S_THREE;
        end
        default: begin
          r_state <= S_EMPTY;
        end
      endcase
    end
  end

  // Output frame register: loads only when a frame completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_desord[0] <= '0;
      r_desord[1] <= '0;
      r_desord[2] <= '0;
      r_desord[3] <= '0;
      r_cod       <= 1'b0;
    end else if (w_complete) begin
      r_desord[0] <= r_buf[0];
      r_desord[1] <= r_buf[1];
      r_desord[2] <= r_buf[2];
      r_desord[3] <= bus.in_data;
      r_cod       <= r_dir;
    end
  end

  // A completion on the handoff edge keeps ena high for the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ena <= 1'b0;
    end else if (w_complete) begin
      r_ena <= 1'b1;
    end else if (w_handoff) begin
      r_ena <= 1'b0;
    end
  end

  // Handed-off frame counter; wraps naturally at 8 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (w_handoff) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.ena           = r_ena;
  assign bus.cresc_ou_desc = r_cod;
  assign bus.frame_cnt     = r_cnt;

  for (genvar g = 0; g < 4; g++) begin : g_out
    assign bus.desordenado[g] = r_desord[g];
  end

endmodule

// File: tb/tb_agrupa_4_num.sv
module tb_agrupa_4_num;

  localparam int W = 9;

  typedef struct packed {
    logic             dir;
    logic [3:0][W-1:0] d;
  } frame_t;

  logic clk;
  logic rst_n;
  int   vec;
  int   misc;
  int   exp_cnt;
  frame_t exp_q [$];

  agrupa_4_num_if #(.W(W)) bus ();

  agrupa_4_num #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    vec++;
    if (got != want) begin
      misc++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic frame_t mk(input int a, input int b, input int c, input int d,
                                input logic dir);
    frame_t f;
    f.dir  = dir;
    f.d[0] = W'(a);
    f.d[1] = W'(b);
    f.d[2] = W'(c);
    f.d[3] = W'(d);
    return f;
  endfunction

  function automatic frame_t cur_out();
    frame_t f;
    f.dir = bus.cresc_ou_desc;
    for (int k = 0; k < 4; k++) f.d[k] = bus.desordenado[k];
    return f;
  endfunction

  // Monitor: every handoff (ena && out_ready seen before the edge) pops one
  // expected frame; the frame counter is checked against the handoff tally.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_cnt = 0;
    end else if (bus.ena && bus.out_ready) begin
      frame_t got;
      frame_t want;
      got = cur_out();
      vec++;
      if (exp_q.size() == 0) begin
        misc++;
        $display("FAIL unexpected_frame: got %0d/%0d/%0d/%0d dir %0b, expected none",
                 got.d[0], got.d[1], got.d[2], got.d[3], got.dir);
      end else begin
        want = exp_q.pop_front();
        if (got != want) begin
          misc++;
          $display("FAIL frame: got %0d/%0d/%0d/%0d dir %0b, expected %0d/%0d/%0d/%0d dir %0b",
                   got.d[0], got.d[1], got.d[2], got.d[3], got.dir,
                   want.d[0], want.d[1], want.d[2], want.d[3], want.dir);
        end
      end
      check("frame_cnt_at_handoff", int'(bus.frame_cnt), exp_cnt & 255);
      exp_cnt++;
    end
  end

  // Present one word and hold it until it is accepted (bounded wait).
  task automatic send_word(input int d, input logic dir);
    int n;
    bus.in_valid         = 1'b1;
    bus.in_data          = W'(d);
    bus.in_cresc_ou_desc = dir;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 200);
    if (!bus.in_ready) begin
      vec++;
      misc++;
      $display("FAIL accept_timeout: word %0d not accepted, expected acceptance", d);
    end
    @(posedge clk);
    #1;
    bus.in_valid         = 1'b0;
    bus.in_cresc_ou_desc = 1'b0;
  endtask

  task automatic send_frame(input int a, input int b, input int c, input int d,
                            input logic dir);
    send_word(a, dir);
    send_word(b, 1'b0);
    send_word(c, 1'b0);
    send_word(d, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    frame_t snap;
    int     stable_bad;
    vec = 0;
    misc = 0;
    rst_n                = 1'b0;
    bus.in_valid         = 1'b0;
    bus.in_data          = '0;
    bus.in_cresc_ou_desc = 1'b0;
    bus.flush            = 1'b0;
    bus.out_ready        = 1'b0;
    idle(3);
    rst_n = 1'b1;

    // Reset state and first-cycle readiness.
    @(negedge clk);
    check("rst_ena", int'(bus.ena), 0);
    check("rst_frame_cnt", int'(bus.frame_cnt), 0);
    check("rst_cod", int'(bus.cresc_ou_desc), 0);
    check("rst_desord", int'(cur_out()), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;

    // Basic frame, ena one cycle after word 4 presented.
    bus.out_ready = 1'b1;
    exp_q.push_back(mk(1, 2, 3, 4, 1'b0));
    send_frame(1, 2, 3, 4, 1'b0);
    check("ena_after_w4", int'(bus.ena), 1);
    idle(1);
    check("ena_clear_after_handoff", int'(bus.ena), 0);
    check("frame_cnt_one", int'(bus.frame_cnt), 1);

    // Held frame with stall; next frame partially filled meanwhile.
    bus.out_ready = 1'b0;
    exp_q.push_back(mk(4, 3, 2, 1, 1'b1));
    send_frame(4, 3, 2, 1, 1'b1);
    check("held_cod", int'(bus.cresc_ou_desc), 1);
    check("held_ena", int'(bus.ena), 1);
    snap = cur_out();
    exp_q.push_back(mk(5, 6, 7, 8, 1'b0));
    send_word(5, 1'b0);
    send_word(6, 1'b0);
    send_word(7, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = W'(8);
    stable_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.in_ready || !bus.ena || cur_out() != snap) stable_bad++;
      @(posedge clk);
      #1;
    end
    check("stall_stable_cycles_bad", stable_bad, 0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("in_ready_on_release", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("ena_kept_on_reload", int'(bus.ena), 1);
    check("reload_word0", int'(bus.desordenado[0]), 5);
    idle(2);
    check("frame_cnt_three", int'(bus.frame_cnt), 3);

    // Back-to-back frames with continuous out_ready.
    exp_q.push_back(mk(21, 22, 23, 24, 1'b0));
    exp_q.push_back(mk(31, 32, 33, 34, 1'b1));
    exp_q.push_back(mk(41, 42, 43, 44, 1'b0));
    send_frame(21, 22, 23, 24, 1'b0);
    send_frame(31, 32, 33, 34, 1'b1);
    send_frame(41, 42, 43, 44, 1'b0);
    idle(2);
    check("frame_cnt_six", int'(bus.frame_cnt), 6);

    // Flush drops a partial frame and the word presented with it.
    exp_q.push_back(mk(10, 11, 12, 13, 1'b0));
    send_word(9, 1'b0);
    send_word(8, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = W'(7);
    bus.flush    = 1'b1;
    @(negedge clk);
    check("in_ready_during_flush", int'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    send_frame(10, 11, 12, 13, 1'b0);
    idle(2);
    check("frame_cnt_seven", int'(bus.frame_cnt), 7);

    // Asynchronous reset with a held frame and two buffered words.
    bus.out_ready = 1'b0;
    send_frame(100, 101, 102, 103, 1'b1);
    send_word(50, 1'b1);
    send_word(51, 1'b0);
    check("pre_reset_ena", int'(bus.ena), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_ena", int'(bus.ena), 0);
    check("async_rst_desord", int'(cur_out()), 0);
    check("async_rst_cnt", int'(bus.frame_cnt), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    exp_q.push_back(mk(511, 0, 255, 1, 1'b0));
    send_frame(511, 0, 255, 1, 1'b0);
    idle(2);
    check("post_rst_cnt", int'(bus.frame_cnt), 1);

    // 255 more handoffs: counter wraps 255 -> 0.
    for (int f = 0; f < 255; f++) begin
      exp_q.push_back(mk((f * 4) & 511, (f * 4 + 1) & 511, (f * 4 + 2) & 511,
                         (f * 4 + 3) & 511, f[0]));
      send_frame((f * 4) & 511, (f * 4 + 1) & 511, (f * 4 + 2) & 511,
                 (f * 4 + 3) & 511, f[0]);
    end
    idle(3);
    check("frame_cnt_wrap", int'(bus.frame_cnt), 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, misc);
    $finish;
  end

endmodule

// File: doc/agrupa_4_num.md
AGRUPA_4_NUM -- requirements
Module: agrupa_4_num

Interface
REQ-001 Parameter: W, 9, bit width of every data word; the frame depth is fixed at 4.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream word present on in_data.
REQ-005 in_ready  output  1  block can accept a word this cycle.
REQ-006 in_data  input  W  serial data word.
REQ-007 in_cresc_ou_desc  input  1  sort direction for the frame, sampled with word 0 of each frame.
REQ-008 flush  input  1  synchronous discard of the partial frame.
REQ-009 desordenado  output  4 x W  unpacked array [3:0]; assembled frame feeding the sorter.
REQ-010 ena  output  1  frame valid; drives the sorter enable.
REQ-011 cresc_ou_desc  output  1  direction captured for the held frame.
REQ-012 out_ready  input  1  downstream consumed the frame.
REQ-013 frame_cnt  output  8  count of frames handed off.

Function
REQ-014 An input transfer SHALL occur on a rising edge where in_valid && in_ready are both 1.
REQ-015 The fill buffer SHALL hold 0..3 words; fill count is the state: EMPTY(0), ONE(1), TWO(2), THREE(3), incremented per transfer.
REQ-016 The word accepted in EMPTY SHALL become desordenado[0]; subsequent words fill [1], [2], [3] in arrival order.
REQ-017 in_cresc_ou_desc SHALL be captured on the EMPTY-state transfer only and held for that frame.
REQ-018 A transfer in THREE SHALL complete the frame: the 3 buffered words plus in_data load the output register, the captured direction loads cresc_ou_desc, ena is set to 1, and the fill state returns to EMPTY, all on the same edge.
REQ-019 Output handoff SHALL occur on an edge where ena && out_ready are both 1; ena then clears unless a new frame completes on that same edge, in which case ena stays 1 and the new frame loads.
REQ-020 desordenado and cresc_ou_desc SHALL stay stable while ena=1 and out_ready=0.
REQ-021 in_ready SHALL be combinational: 0 when flush=1; 0 when state=THREE && ena=1 && out_ready=0; otherwise 1.
REQ-022 Words SHALL be accepted into EMPTY..TWO while a full frame is held, giving ping-pong overlap of frame fill and frame drain.
REQ-023 Latency SHALL be: ena rises on the edge that accepts word 3, so the frame is visible 1 cycle after its last word is presented.
REQ-024 flush=1 SHALL return the fill state to EMPTY and discard the buffered words; it SHALL NOT affect ena, desordenado or frame_cnt; flush takes priority over a simultaneous in_valid.
REQ-025 frame_cnt SHALL increment by 1 per output handoff and wrap from 255 to 0.
REQ-026 in_data values SHALL pass unmodified (no width change, no sign handling).
REQ-027 in_valid while in_ready=0 SHALL have no effect; upstream holds in_data.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for clk, force: fill state EMPTY, ena=0, desordenado all 0, cresc_ou_desc=0, frame_cnt=0.
REQ-029 A reset asserted mid-frame or with ena=1 SHALL discard all data; the first word after release is word 0 of a new frame.
REQ-030 in_ready SHALL be 1 in the first cycle after release (flush=0).

Verification
REQ-031 Words 1,2,3,4 with in_valid=1 every cycle, out_ready=1 -> ena=1 one cycle after word 4 is presented, desordenado={1,2,3,4} by index 0..3, frame_cnt=1 after the handoff.
REQ-032 Frame 4,3,2,1 with in_cresc_ou_desc=1 on word 0 then 0 on words 1-3 -> cresc_ou_desc=1; out_ready=0 for 10 cycles -> outputs stable; second frame 5,6,7 accepted, in_ready=0 at the 4th word until out_ready=1.
REQ-033 Back-to-back frames with out_ready=1 continuously -> ena held 1 across the boundary, new frame loaded on the same edge, no word lost, frame_cnt increments each frame.
REQ-034 Words 9,8 then flush=1 together with in_valid=1 for word 7 -> 7 dropped; next words 10,11,12,13 -> desordenado={10,11,12,13}.
REQ-035 rst_n pulsed low between clock edges with ena=1 and state TWO -> outputs zero immediately; after release, words 511,0,255,1 -> desordenado={511,0,255,1}.
REQ-036 256 frames handed off -> frame_cnt wraps to 0.
